multicycle_main_fsm: RTL and testbench
======================================

Name: multicycle_main_fsm

Overview:
- Main control state machine for the multicycle Filter-GPU core.
- Sequences the shared ALU, instruction/data memory port and register file across the fetch, decode, execute, memory and writeback steps.
- The ALU operation select (alu_op) feeds the existing ALU decoder, which resolves the Funct-specific ALU control.
- Stalls on a memory ready handshake. Optionally holds the execute step for a multi-cycle multiply.

Parameters:
- MUL_CYCLES, 4, number of EXEC_MUL cycles; legal range 2..15; used only when MUL_MULTICYCLE_EN is defined.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high.
- Op  in  2  instruction op field: 00 data processing, 01 memory, 10 branch, 11 illegal.
- Funct  in  6  instruction funct field: [5] I (immediate), [4:1] cmd, [0] S for data processing, L for memory.
- mem_ready  in  1  memory completes the current access this cycle.
- ir_write  out  1  latch instruction register.
- next_pc  out  1  update PC.
- adr_src  out  1  address select: 0 PC, 1 ALU result.
- alu_src_a  out  2  ALU A operand select.
- alu_src_b  out  2  ALU B operand select.
- alu_op  out  1  1 selects data-processing decode in the ALU decoder.
- result_src  out  2  result select: 00 ALUOut, 01 read data, 10 ALU result.
- reg_w  out  1  register file write.
- mem_w  out  1  memory write request.
- branch  out  1  branch step; PC update is conditional downstream.
- illegal  out  1  one-cycle pulse on an Op=11 decode.
- state_o  out  4  current state encoding, for debug.

Behaviour:
- Single clock domain. reset is synchronous and active-high. Reset has priority over every transition, including mid-instruction and mid-wait.
- On reset: state goes to FETCH, and the FETCH output values appear in the cycle after reset deasserts.
- Outputs are Moore (a function of state only), except ir_write and next_pc, which are gated by mem_ready.
- Outputs not listed for a state are 0.

State encoding:
- FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECR=6, EXECI=7, ALUWB=8, BRANCH=9, EXEC_MUL=10.
- Codes 11..15 are unreachable; if entered, the next state is FETCH.

Per-state outputs:
- FETCH: adr_src=0, alu_src_a=01, alu_src_b=10, result_src=10, ir_write=mem_ready, next_pc=mem_ready.
  - Stays in FETCH while mem_ready=0; otherwise goes to DECODE.
- DECODE: alu_src_a=01, alu_src_b=10, result_src=10.
  - Op=00 and Funct[5]=1: go to EXECI.
  - Op=00 and Funct[5]=0: go to EXECR.
  - Op=01: go to MEMADR.
  - Op=10: go to BRANCH.
  - Op=11: illegal=1 for this cycle, then go to FETCH (instruction treated as a NOP).
- EXECR: alu_src_b=00, alu_op=1. Next state ALUWB.
- EXECI: alu_src_b=01, alu_op=1. Next state ALUWB.
- ALUWB: result_src=00, reg_w=1. Next state FETCH.
- MEMADR: alu_src_b=01.
  - Funct[0]=1 (load): go to MEMRD.
  - Funct[0]=0 (store): go to MEMWR.
- MEMRD: adr_src=1. Stays while mem_ready=0; otherwise goes to MEMWB.
- MEMWB: result_src=01, reg_w=1. Next state FETCH.
- MEMWR: adr_src=1, mem_w=1, held high for the whole wait. Stays while mem_ready=0; otherwise goes to FETCH.
- BRANCH: alu_src_b=01, result_src=10, branch=1. Next state FETCH.

Latency with mem_ready tied to 1:
- Data processing: 4 cycles.
- Load (LDR): 5 cycles.
- Store (STR): 4 cycles.
- Branch (B): 3 cycles.
- Illegal: 2 cycles.
- Each mem_ready=0 cycle in FETCH, MEMRD or MEMWR adds exactly one cycle.

Other rules:
- mem_ready is ignored in all states other than FETCH, MEMRD and MEMWR.
- Op and Funct are sampled only in DECODE and MEMADR; the instruction register holds them stable.

Optional Feature:
- Macro: MUL_MULTICYCLE_EN.
- Defined: a DECODE with Op=00, Funct[5]=0 and Funct[4:1]=0001 (MUL) goes to EXEC_MUL instead of EXECR.
  - EXEC_MUL drives alu_src_b=00 and alu_op=1.
  - A 4-bit counter loads MUL_CYCLES-1 on entry and decrements each cycle; the state moves to ALUWB in the cycle after the counter reads 0.
  - EXEC_MUL therefore lasts exactly MUL_CYCLES cycles; MUL total latency is MUL_CYCLES+3.
  - Reset clears the counter.
- Undefined: EXEC_MUL and the counter do not exist. MUL follows the EXECR path, 4 cycles total.

Test Plan:
- Reset: hold reset 3 cycles during a MEMRD wait, then release -> state_o=0, reg_w=0, mem_w=0, and ir_write=1 in the first cycle with mem_ready=1.
- ADD register form, Op=00, Funct=001000, mem_ready=1 -> state sequence 0,1,6,8,0; alu_op=1 only in state 6; reg_w=1 only in state 8.
- LDR, Op=01, Funct=011001, mem_ready low for 2 cycles in MEMRD -> sequence 0,1,2,3,3,3,4,0; adr_src=1 in the three state-3 cycles; result_src=01 in state 4.
- STR, Op=01, Funct=011000, mem_ready low for 1 cycle in FETCH -> sequence 0,0,1,2,5,0; ir_write=0 in the first FETCH cycle; mem_w=1 only in state 5.
- Branch Op=10 -> sequence 0,1,9,0 with branch=1 in state 9. Illegal Op=11 -> illegal=1 in DECODE only, then FETCH.
- With MUL_MULTICYCLE_EN and MUL_CYCLES=4: Op=00, Funct=000010 -> state 10 for exactly 4 cycles, then 8, then 0. Without the macro -> sequence 0,1,6,8,0.

Source files
------------

// File: rtl/multicycle_main_fsm.sv
// -----------------------------------------------------------------------------
// multicycle_main_fsm
//
// Main control state machine for the multicycle Filter-GPU core. It sequences
// the shared ALU, the combined instruction/data memory port and the register
// file through fetch, decode, execute, memory and writeback steps. It stalls
// on the memory ready handshake.
//
// Optional feature (macro MUL_MULTICYCLE_EN): when defined, a data-processing
// MUL (register form, cmd = 0001) is held in EXEC_MUL for MUL_CYCLES cycles
// before writeback. When undefined, MUL takes the ordinary EXECR path.
//
// Parameters:
//   MUL_CYCLES  length of EXEC_MUL in cycles (2..15). It is used only with
//               MUL_MULTICYCLE_EN, but its range is always checked.
//
// Ports:
//   clk         clock, rising edge
//   reset       synchronous active-high reset; it wins over every transition
//   Op          instruction op field (00 DP, 01 mem, 10 branch, 11 illegal)
//   Funct       instruction funct field ([5] I, [4:1] cmd, [0] S/L)
//   mem_ready   memory completes the current access this cycle
//   ir_write    latch the instruction register (FETCH, gated by mem_ready)
//   next_pc     update the PC (FETCH, gated by mem_ready)
//   adr_src     memory address select: 0 = PC, 1 = ALU result
//   alu_src_a   ALU A operand select
//   alu_src_b   ALU B operand select
//   alu_op      1 selects data-processing decode in the ALU decoder
//   result_src  result select: 00 ALUOut, 01 read data, 10 ALU result
//   reg_w       register file write
//   mem_w       memory write request
//   branch      branch step; the PC update is made conditional downstream
//   illegal     one-cycle pulse when DECODE sees Op = 11
//   state_o     current state encoding, for debug
// -----------------------------------------------------------------------------
module multicycle_main_fsm #(
    parameter int MUL_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    input  logic       mem_ready,
    output logic       ir_write,
    output logic       next_pc,
    output logic       adr_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic       alu_op,
    output logic [1:0] result_src,
    output logic       reg_w,
    output logic       mem_w,
    output logic       branch,
    output logic       illegal,
    output logic [3:0] state_o
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMRD    = 4'd3,
        MEMWB    = 4'd4,
        MEMWR    = 4'd5,
        EXECR    = 4'd6,
        EXECI    = 4'd7,
        ALUWB    = 4'd8,
        BRANCH   = 4'd9,
        EXEC_MUL = 4'd10
    } state_t;

    state_t state_reg;
    state_t state_next;

    // The parameter range is checked at elaboration.
    generate
        if (MUL_CYCLES < 2 || MUL_CYCLES > 15) begin : g_bad_mul_cycles
            $error("multicycle_main_fsm: MUL_CYCLES must be in 2..15");
        end
    endgenerate

`ifdef MUL_MULTICYCLE_EN
    logic [3:0] mul_cnt_reg;
    logic       is_mul;

    // Register-form data-processing instruction whose cmd is MUL.
    assign is_mul = (Funct[5] == 1'b0) && (Funct[4:1] == 4'b0001);

    // The counter is loaded on entry and counts down to 0. The state leaves
    // EXEC_MUL in the cycle after the counter reads 0, so EXEC_MUL lasts
    // exactly MUL_CYCLES cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            mul_cnt_reg <= 4'd0;
        end else if (state_reg == DECODE && state_next == EXEC_MUL) begin
            mul_cnt_reg <= 4'(MUL_CYCLES - 1);
        end else if (state_reg == EXEC_MUL && mul_cnt_reg != 4'd0) begin
            mul_cnt_reg <= mul_cnt_reg - 4'd1;
        end
    end
`else
    // Without the multi-cycle multiply, the cmd bits are not needed here.
    // The ALU decoder consumes them.
    logic unused_cmd;
    assign unused_cmd = ^Funct[4:1];
`endif

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= FETCH;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = FETCH;
        case (state_reg)
            FETCH:  state_next = mem_ready ? DECODE : FETCH;
            DECODE: begin
                case (Op)
                    2'b00: begin
                        if (Funct[5]) begin
                            state_next = EXECI;
                        end else begin
`ifdef MUL_MULTICYCLE_EN
                            state_next = is_mul ? EXEC_MUL : EXECR;
`else
                            state_next = EXECR;
`endif
                        end
                    end
                    2'b01:   state_next = MEMADR;
                    2'b10:   state_next = BRANCH;
                    default: state_next = FETCH;  // illegal op: treated as a NOP
                endcase
            end
            MEMADR: state_next = Funct[0] ? MEMRD : MEMWR;
            MEMRD:  state_next = mem_ready ? MEMWB : MEMRD;
            MEMWB:  state_next = FETCH;
            MEMWR:  state_next = mem_ready ? FETCH : MEMWR;
            EXECR:  state_next = ALUWB;
            EXECI:  state_next = ALUWB;
            ALUWB:  state_next = FETCH;
            BRANCH: state_next = FETCH;
`ifdef MUL_MULTICYCLE_EN
            EXEC_MUL: state_next = (mul_cnt_reg == 4'd0) ? ALUWB : EXEC_MUL;
`endif
            default: state_next = FETCH;  // unreachable codes recover to FETCH
        endcase
    end

    // Output logic. The outputs are Moore outputs, except that ir_write and
    // next_pc in FETCH follow mem_ready. illegal is a DECODE-only pulse.
    always_comb begin
        ir_write   = 1'b0;
        next_pc    = 1'b0;
        adr_src    = 1'b0;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        alu_op     = 1'b0;
        result_src = 2'b00;
        reg_w      = 1'b0;
        mem_w      = 1'b0;
        branch     = 1'b0;
        illegal    = 1'b0;
        case (state_reg)
            FETCH: begin
                alu_src_a  = 2'b01;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                ir_write   = mem_ready;
                next_pc    = mem_ready;
            end
            DECODE: begin
                alu_src_a  = 2'b01;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                illegal    = (Op == 2'b11);
            end
            MEMADR: alu_src_b = 2'b01;
            MEMRD:  adr_src = 1'b1;
            MEMWB: begin
                result_src = 2'b01;
                reg_w      = 1'b1;
            end
            MEMWR: begin
                adr_src = 1'b1;
                mem_w   = 1'b1;  // held for the whole wait
            end
            EXECR: begin
                alu_src_b = 2'b00;
                alu_op    = 1'b1;
            end
            EXECI: begin
                alu_src_b = 2'b01;
                alu_op    = 1'b1;
            end
            ALUWB: begin
                result_src = 2'b00;
                reg_w      = 1'b1;
            end
            BRANCH: begin
                alu_src_b  = 2'b01;
                result_src = 2'b10;
                branch     = 1'b1;
            end
`ifdef MUL_MULTICYCLE_EN
            EXEC_MUL: begin
                alu_src_b = 2'b00;
                alu_op    = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    assign state_o = state_reg;

endmodule

// File: tb/tb_multicycle_main_fsm.sv
// -----------------------------------------------------------------------------
// tb_multicycle_main_fsm
//
// Scoreboard bench for multicycle_main_fsm. For each instruction, the driver
// builds the expected cycle-by-cycle state list from the instruction class and
// the injected wait counts. It drives mem_ready and pushes the expected output
// vector for every cycle into a queue. A monitor pops the queue and compares
// the DUT outputs on each falling edge.
// -----------------------------------------------------------------------------
module tb_multicycle_main_fsm;

    localparam int MUL_CYCLES = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic       mem_ready;
    logic       ir_write, next_pc, adr_src, alu_op, reg_w, mem_w, branch, illegal;
    logic [1:0] alu_src_a, alu_src_b, result_src;
    logic [3:0] state_o;

    int n_checks = 0;
    int n_fail   = 0;

    logic [17:0] exp_q[$];
    logic [3:0]  seq_st[$];
    logic        seq_mr[$];

    multicycle_main_fsm #(.MUL_CYCLES(MUL_CYCLES)) dut (
        .clk        (clk),
        .reset      (reset),
        .Op         (Op),
        .Funct      (Funct),
        .mem_ready  (mem_ready),
        .ir_write   (ir_write),
        .next_pc    (next_pc),
        .adr_src    (adr_src),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op),
        .result_src (result_src),
        .reg_w      (reg_w),
        .mem_w      (mem_w),
        .branch     (branch),
        .illegal    (illegal),
        .state_o    (state_o)
    );

    always #5 clk = ~clk;

    // Expected outputs of a state, taken directly from the per-state table.
    // The vector is packed as {state, ir_write, next_pc, adr_src, alu_src_a,
    // alu_src_b, alu_op, result_src, reg_w, mem_w, branch, illegal}.
    function automatic logic [17:0] exp_vec(input logic [3:0] st, input logic mr,
                                            input logic [1:0] op);
        logic ir = 0, npc = 0, adr = 0, aop = 0, rw = 0, mw = 0, br = 0, il = 0;
        logic [1:0] a = 0, b = 0, res = 0;
        case (st)
            4'd0:  begin a = 2'b01; b = 2'b10; res = 2'b10; ir = mr; npc = mr; end
            4'd1:  begin a = 2'b01; b = 2'b10; res = 2'b10; il = (op == 2'b11); end
            4'd2:  b = 2'b01;
            4'd3:  adr = 1;
            4'd4:  begin res = 2'b01; rw = 1; end
            4'd5:  begin adr = 1; mw = 1; end
            4'd6:  begin b = 2'b00; aop = 1; end
            4'd7:  begin b = 2'b01; aop = 1; end
            4'd8:  begin res = 2'b00; rw = 1; end
            4'd9:  begin b = 2'b01; res = 2'b10; br = 1; end
            4'd10: begin b = 2'b00; aop = 1; end
            default: ;
        endcase
        return {st, ir, npc, adr, a, b, aop, res, rw, mw, br, il};
    endfunction

    task automatic add(input logic [3:0] st, input logic mr);
        seq_st.push_back(st);
        seq_mr.push_back(mr);
    endtask

    // Builds the expected state sequence of one instruction. The sequence
    // starts in FETCH. A wait count is the number of mem_ready=0 cycles in
    // FETCH or in the memory access state. In states that ignore mem_ready,
    // mem_ready is random.
    task automatic build(input logic [1:0] op, input logic [5:0] fn,
                         input int fw, input int mw);
        seq_st.delete();
        seq_mr.delete();
        repeat (fw) add(4'd0, 1'b0);
        add(4'd0, 1'b1);
        add(4'd1, 1'($urandom));
        case (op)
            2'b00: begin
`ifdef MUL_MULTICYCLE_EN
                if (!fn[5] && fn[4:1] == 4'b0001)
                    repeat (MUL_CYCLES) add(4'd10, 1'($urandom));
                else
`endif
                add(fn[5] ? 4'd7 : 4'd6, 1'($urandom));
                add(4'd8, 1'($urandom));
            end
            2'b01: begin
                add(4'd2, 1'($urandom));
                if (fn[0]) begin
                    repeat (mw) add(4'd3, 1'b0);
                    add(4'd3, 1'b1);
                    add(4'd4, 1'($urandom));
                end else begin
                    repeat (mw) add(4'd5, 1'b0);
                    add(4'd5, 1'b1);
                end
            end
            2'b10: add(4'd9, 1'($urandom));
            default: ;
        endcase
    endtask

    // Drives the inputs for one cycle and records the expected outputs.
    // The task is called #1 after a rising edge and returns #1 after the next
    // rising edge.
    task automatic drive(input logic [3:0] st, input logic mr, input logic rst);
        reset     = rst;
        mem_ready = mr;
        exp_q.push_back(exp_vec(st, mr, Op));
        @(posedge clk);
        #1;
    endtask

    task automatic run_instr(input logic [1:0] op, input logic [5:0] fn,
                             input int fw, input int mw);
        build(op, fn, fw, mw);
        Op    = op;
        Funct = fn;
        $display("instr op=%b funct=%b fetch_wait=%0d mem_wait=%0d cycles=%0d",
                 op, fn, fw, mw, seq_st.size());
        for (int i = 0; i < seq_st.size(); i++) drive(seq_st[i], seq_mr[i], 1'b0);
    endtask

    // Monitor. The DUT presents an output vector every cycle. Each vector is
    // compared with the expected vector for that cycle, if one was pushed.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [17:0] e;
            logic [17:0] g;
            e = exp_q.pop_front();
            g = {state_o, ir_write, next_pc, adr_src, alu_src_a, alu_src_b, alu_op,
                 result_src, reg_w, mem_w, branch, illegal};
            n_checks++;
            if (g !== e) begin
                n_fail++;
                $display("FAIL cycle_outputs t=%0t got state=%0d vec=%05h expected state=%0d vec=%05h",
                         $time, g[17:14], g, e[17:14], e);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset     = 1'b1;
        mem_ready = 1'b0;
        Op        = 2'b00;
        Funct     = 6'b000000;
        repeat (2) @(posedge clk);
        #1;
        drive(4'd0, 1'b0, 1'b1);  // reset still held: FETCH with no handshake

        // Directed instructions from the test plan
        run_instr(2'b00, 6'b001000, 0, 0);  // ADD register form
        run_instr(2'b01, 6'b011001, 0, 2);  // LDR with 2 waits in MEMRD
        run_instr(2'b01, 6'b011000, 1, 0);  // STR with 1 wait in FETCH
        run_instr(2'b10, 6'b000000, 0, 0);  // B
        run_instr(2'b11, 6'b000000, 0, 0);  // illegal
        run_instr(2'b00, 6'b000010, 0, 0);  // MUL
        run_instr(2'b00, 6'b100010, 0, 0);  // immediate form
        run_instr(2'b01, 6'b011000, 0, 3);  // STR with 3 waits in MEMWR

        // Reset held for 3 cycles during a MEMRD wait
        Op    = 2'b01;
        Funct = 6'b011001;
        $display("instr reset_in_memrd");
        drive(4'd0, 1'b1, 1'b0);
        drive(4'd1, 1'($urandom), 1'b0);
        drive(4'd2, 1'($urandom), 1'b0);
        drive(4'd3, 1'b0, 1'b0);
        drive(4'd3, 1'b0, 1'b1);
        drive(4'd0, 1'b0, 1'b1);
        drive(4'd0, 1'b0, 1'b1);
        run_instr(2'b01, 6'b011001, 0, 0);  // first FETCH after release: ir_write=1

        // Random instructions
        for (int n = 0; n < 150; n++) begin
            logic [1:0] op;
            logic [5:0] fn;
            int fw, mw;
            op = 2'($urandom_range(0, 3));
            fn = 6'($urandom);
            if (op == 2'b00 && $urandom_range(0, 3) == 0) fn[4:1] = 4'b0001;
            fw = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 3);
            mw = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 3);
            run_instr(op, fn, fw, mw);
        end

        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain got %0d pending expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
